// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundles the raster-enable input and all timing outputs of vga_timing_gen.
//   master : the timing generator (drives address, flags and syncs)
//   slave  : the consumer side (drives the enable, observes the outputs)
//
//   i_en          raster advance enable; low freezes the generator
//   o_vga_addr    linear pixel address y*H_ACTIVE+x (19 bits)
//   o_active      undelayed active-video flag, aligned with o_vga_addr
//   o_frame_start one-cycle pulse when the raster is at (0,0)
//   o_hsync       horizontal sync, delayed to match the RGB pipeline
//   o_vsync       vertical sync, delayed to match the RGB pipeline
//   o_blank_n     high in active video, delayed to match the RGB pipeline
// ---------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic        i_en;
  logic [18:0] o_vga_addr;
  logic        o_active;
  logic        o_frame_start;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_blank_n;

  modport master (
    input  i_en,
    output o_vga_addr,
    output o_active,
    output o_frame_start,
    output o_hsync,
    output o_vsync,
    output o_blank_n
  );

  modport slave (
    output i_en,
    input  o_vga_addr,
    input  o_active,
    input  o_frame_start,
    input  o_hsync,
    input  o_vsync,
    input  o_blank_n
  );
endinterface

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   VGA raster timing generator (640x480@60 by default) on the pixel clock.
//   Produces the linear frame-memory address plus an undelayed active flag
//   and frame-start pulse, and hsync/vsync/blank_n delayed by PIPE_DLY
//   enabled cycles so they line up with RGB returned by the memory stage.
//
//   i_vga_clk  pixel clock, the only clock
//   rst_n      synchronous active-low reset (priority over enable)
//   vif        vga_timing_gen_if.master: i_en in; o_vga_addr, o_active,
//              o_frame_start, o_hsync, o_vsync, o_blank_n out (all registered)
// ---------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int PIPE_DLY = 2
) (
  input  logic             i_vga_clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0);
  localparam logic SYNC_OFF = (SYNC_POL == 0);

  // h_cnt_r/v_cnt_r hold the raster position that the next enabled edge
  // will present on the outputs; addr_nxt_r is the address for that
  // position. This is what lets the first enabled edge after reset show
  // (0,0) with frame_start and active already decoded.
  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic [18:0]   addr_nxt_r;

  logic [18:0]   addr_r;
  logic          active_r;
  logic          frame_start_r;
  logic          hsync_r;
  logic          vsync_r;
  logic          blank_n_r;

  logic          active_s;
  logic          origin_s;
  logic          h_last_s;
  logic          v_last_s;
  logic          hs_lvl_s;
  logic          vs_lvl_s;

  // Position decode: active window, sync levels and wrap points.
  always_comb begin
    active_s = 1'b0;
    origin_s = 1'b0;
    h_last_s = 1'b0;
    v_last_s = 1'b0;
    hs_lvl_s = SYNC_OFF;
    vs_lvl_s = SYNC_OFF;

    h_last_s = (h_cnt_r == H_LAST);
    v_last_s = (v_cnt_r == V_LAST);
    origin_s = (h_cnt_r == '0) && (v_cnt_r == '0);
    active_s = (h_cnt_r < H_ACT_END) && (v_cnt_r < V_ACT_END);

    if ((h_cnt_r >= HS_START) && (h_cnt_r <= HS_END)) begin
      hs_lvl_s = SYNC_ON;
    end else begin
      hs_lvl_s = SYNC_OFF;
    end

    if ((v_cnt_r >= VS_START) && (v_cnt_r <= VS_END)) begin
      vs_lvl_s = SYNC_ON;
    end else begin
      vs_lvl_s = SYNC_OFF;
    end
  end

  // Raster counters, address and the undelayed outputs.
  always_ff @(posedge i_vga_clk) begin
    if (!rst_n) begin
      h_cnt_r       <= '0;
      v_cnt_r       <= '0;
      addr_nxt_r    <= '0;
      addr_r        <= '0;
      active_r      <= 1'b0;
      frame_start_r <= 1'b0;
    end else if (vif.i_en) begin
      addr_r        <= addr_nxt_r;
      active_r      <= active_s;
      frame_start_r <= origin_s;

      if (h_last_s) begin
        h_cnt_r <= '0;
        if (v_last_s) begin
          v_cnt_r <= '0;
        end else begin
          v_cnt_r <= v_cnt_r + VW'(1);
        end
      end else begin
        h_cnt_r <= h_cnt_r + HW'(1);
      end

      // The address only advances past visible pixels, so during blanking
      // it already points at the first pixel of the next visible line.
      if (h_last_s && v_last_s) begin
        addr_nxt_r <= '0;
      end else if (active_s) begin
        addr_nxt_r <= addr_nxt_r + 19'd1;
      end else begin
        addr_nxt_r <= addr_nxt_r;
      end
    end else begin
      // Frozen: everything holds except the pulse, which must not stretch.
      frame_start_r <= 1'b0;
    end
  end

  generate
    if (PIPE_DLY == 0) begin : g_no_dly
      // Sync/blank registered straight from the decode, no extra lag.
      always_ff @(posedge i_vga_clk) begin
        if (!rst_n) begin
          hsync_r   <= SYNC_OFF;
          vsync_r   <= SYNC_OFF;
          blank_n_r <= 1'b0;
        end else if (vif.i_en) begin
          hsync_r   <= hs_lvl_s;
          vsync_r   <= vs_lvl_s;
          blank_n_r <= active_s;
        end else begin
          hsync_r   <= hsync_r;
          vsync_r   <= vsync_r;
          blank_n_r <= blank_n_r;
        end
      end
    end else begin : g_dly
      // Bit 0 carries the level of the position being presented now; the
      // output register takes the top bit, giving PIPE_DLY cycles of lag.
      logic [PIPE_DLY-1:0] hs_pipe_r;
      logic [PIPE_DLY-1:0] vs_pipe_r;
      logic [PIPE_DLY-1:0] bn_pipe_r;

      // Delay pipes for sync/blank, advanced only on enabled cycles.
      always_ff @(posedge i_vga_clk) begin
        if (!rst_n) begin
          hs_pipe_r <= {PIPE_DLY{SYNC_OFF}};
          vs_pipe_r <= {PIPE_DLY{SYNC_OFF}};
          bn_pipe_r <= '0;
          hsync_r   <= SYNC_OFF;
          vsync_r   <= SYNC_OFF;
          blank_n_r <= 1'b0;
        end else if (vif.i_en) begin
          hs_pipe_r <= PIPE_DLY'({hs_pipe_r, hs_lvl_s});
          vs_pipe_r <= PIPE_DLY'({vs_pipe_r, vs_lvl_s});
          bn_pipe_r <= PIPE_DLY'({bn_pipe_r, active_s});
          hsync_r   <= hs_pipe_r[PIPE_DLY-1];
          vsync_r   <= vs_pipe_r[PIPE_DLY-1];
          blank_n_r <= bn_pipe_r[PIPE_DLY-1];
        end else begin
          hs_pipe_r <= hs_pipe_r;
          vs_pipe_r <= vs_pipe_r;
          bn_pipe_r <= bn_pipe_r;
          hsync_r   <= hsync_r;
          vsync_r   <= vsync_r;
          blank_n_r <= blank_n_r;
        end
      end
    end
  endgenerate

  assign vif.o_vga_addr    = addr_r;
  assign vif.o_active      = active_r;
  assign vif.o_frame_start = frame_start_r;
  assign vif.o_hsync       = hsync_r;
  assign vif.o_vsync       = vsync_r;
  assign vif.o_blank_n     = blank_n_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//   DUT A: default 640x480 timing, active-low syncs, 2-cycle sync delay.
//   DUT B: tiny 15x8 raster, active-high syncs, no sync delay.
//   Both are compared every cycle against a position-arithmetic model, plus
//   a vector table and hand-written freeze / reset / wrap sequences.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pol, dly;
  } tparam_t;

  typedef struct {
    logic [18:0] addr;
    logic        act;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        bn;
  } outs_t;

  typedef struct {
    int          cyc;
    logic [18:0] addr;
    logic        act;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        bn;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  assign if_a.i_en = en_a;
  assign if_b.i_en = en_b;

  vga_timing_gen dut_a (
    .i_vga_clk (clk),
    .rst_n     (rst_a),
    .vif       (if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .SYNC_POL (1), .PIPE_DLY (0)
  ) dut_b (
    .i_vga_clk (clk),
    .rst_n     (rst_b),
    .vif       (if_b)
  );

  tparam_t ta, tb;
  longint  m_a, m_b;     // enabled edges since the last reset edge
  bit      le_a, le_b;   // last edge was an enabled, non-reset edge
  int      n_checks = 0;
  int      n_fail   = 0;

  // Expected outputs after m enabled edges: position m-1 is on display,
  // delayed signals reflect position m-1-dly (inactive before that exists).
  function automatic outs_t model(input tparam_t t, input longint m, input bit le);
    outs_t  o;
    longint ht, vt, fr, p, x, y, q;
    logic   on;
    on = (t.pol != 0);
    ht = t.ha + t.hfp + t.hsw + t.hbp;
    vt = t.va + t.vfp + t.vsw + t.vbp;
    fr = ht * vt;
    o.addr = '0; o.act = 1'b0; o.fs = 1'b0;
    o.hs = ~on; o.vs = ~on; o.bn = 1'b0;
    if (m > 0) begin
      p = (m - 1) % fr; x = p % ht; y = p / ht;
      o.act = (x < t.ha) && (y < t.va);
      if (y < t.va) o.addr = 19'(y * t.ha + ((x < t.ha) ? x : t.ha));
      else          o.addr = 19'(t.va * t.ha);
      o.fs = le && (p == 0);
      q = m - 1 - t.dly;
      if (q >= 0) begin
        p = q % fr; x = p % ht; y = p / ht;
        o.hs = (x >= t.ha + t.hfp && x < t.ha + t.hfp + t.hsw) ? on : ~on;
        o.vs = (y >= t.va + t.vfp && y < t.va + t.vfp + t.vsw) ? on : ~on;
        o.bn = (x < t.ha) && (y < t.va);
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic outs_t read_a();
    outs_t o;
    o.addr = if_a.o_vga_addr; o.act = if_a.o_active; o.fs = if_a.o_frame_start;
    o.hs = if_a.o_hsync; o.vs = if_a.o_vsync; o.bn = if_a.o_blank_n;
    return o;
  endfunction

  function automatic outs_t read_b();
    outs_t o;
    o.addr = if_b.o_vga_addr; o.act = if_b.o_active; o.fs = if_b.o_frame_start;
    o.hs = if_b.o_hsync; o.vs = if_b.o_vsync; o.bn = if_b.o_blank_n;
    return o;
  endfunction

  task automatic cmp(input string tag, input outs_t g, input outs_t e);
    chk({tag, ".addr"},        32'(g.addr), 32'(e.addr));
    chk({tag, ".active"},      32'(g.act),  32'(e.act));
    chk({tag, ".frame_start"}, 32'(g.fs),   32'(e.fs));
    chk({tag, ".hsync"},       32'(g.hs),   32'(e.hs));
    chk({tag, ".vsync"},       32'(g.vs),   32'(e.vs));
    chk({tag, ".blank_n"},     32'(g.bn),   32'(e.bn));
  endtask

  // One clock: advance the models with the inputs seen at the edge, then
  // compare both DUTs on the following falling edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_a)    begin m_a = 0; le_a = 1'b0; end
    else if (en_a) begin m_a++;   le_a = 1'b1; end
    else                          le_a = 1'b0;
    if (!rst_b)    begin m_b = 0; le_b = 1'b0; end
    else if (en_b) begin m_b++;   le_b = 1'b1; end
    else                          le_b = 1'b0;
    @(negedge clk);
    cmp("A.model", read_a(), model(ta, m_a, le_a));
    cmp("B.model", read_b(), model(tb, m_b, le_b));
  endtask

  vec_t vecs [14];

  initial begin
    int     vi;
    int     guard;
    outs_t  g;

    ta = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 2};
    tb = '{8, 2, 3, 2, 4, 1, 2, 1, 1, 0};
    m_a = 0; m_b = 0; le_a = 1'b0; le_b = 1'b0;

    //            cyc   addr        act   fs    hs    vs    bn
    vecs[0]  = '{0,    19'd0,    1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1,    19'd1,    1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{2,    19'd2,    1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{639,  19'd639,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4]  = '{640,  19'd640,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[5]  = '{642,  19'd640,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{657,  19'd640,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{658,  19'd640,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{753,  19'd640,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{754,  19'd640,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{799,  19'd640,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{800,  19'd640,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{802,  19'd642,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{8300, 19'd6700, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    // Reset both DUTs, enable high to show reset wins.
    rst_a = 1'b0; en_a = 1'b1; rst_b = 1'b0; en_b = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    chk("A.reset.addr",    32'(if_a.o_vga_addr),    32'd0);
    chk("A.reset.active",  32'(if_a.o_active),      32'd0);
    chk("A.reset.hsync",   32'(if_a.o_hsync),       32'd1);
    chk("A.reset.vsync",   32'(if_a.o_vsync),       32'd1);
    chk("A.reset.blank_n", 32'(if_a.o_blank_n),     32'd0);
    chk("B.reset.hsync",   32'(if_b.o_hsync),       32'd0);

    // Release A and walk the vector table along the first lines.
    rst_a = 1'b1; en_a = 1'b1;
    vi = 0;
    for (int k = 0; k <= 8300; k++) begin
      tick();
      if (vi < 14 && vecs[vi].cyc == k) begin
        g = read_a();
        chk($sformatf("A.vec%0d.addr", k),   32'(g.addr), 32'(vecs[vi].addr));
        chk($sformatf("A.vec%0d.active", k), 32'(g.act),  32'(vecs[vi].act));
        chk($sformatf("A.vec%0d.fs", k),     32'(g.fs),   32'(vecs[vi].fs));
        chk($sformatf("A.vec%0d.hsync", k),  32'(g.hs),   32'(vecs[vi].hs));
        chk($sformatf("A.vec%0d.vsync", k),  32'(g.vs),   32'(vecs[vi].vs));
        chk($sformatf("A.vec%0d.blank", k),  32'(g.bn),   32'(vecs[vi].bn));
        vi++;
      end
    end

    // Freeze at (300,10) for 5 cycles, then resume with no skip.
    en_a = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("A.freeze.addr",    32'(if_a.o_vga_addr),    32'd6700);
      chk("A.freeze.fs",      32'(if_a.o_frame_start), 32'd0);
      chk("A.freeze.active",  32'(if_a.o_active),      32'd1);
      chk("A.freeze.hsync",   32'(if_a.o_hsync),       32'd1);
      chk("A.freeze.blank_n", 32'(if_a.o_blank_n),     32'd1);
    end
    en_a = 1'b1;
    tick();
    chk("A.resume.addr0", 32'(if_a.o_vga_addr), 32'd6701);
    tick();
    chk("A.resume.addr1", 32'(if_a.o_vga_addr), 32'd6702);

    // Run to (700,12), inside the hsync pulse, and pulse reset for 1 cycle.
    guard = 0;
    while (m_a - 1 != 10300 && guard < 5000) begin
      tick();
      guard++;
    end
    chk("A.reach_700_12", 32'(m_a - 1), 32'd10300);
    chk("A.pre_reset.hsync", 32'(if_a.o_hsync), 32'd0);
    rst_a = 1'b0;
    tick();
    chk("A.midrst.addr",    32'(if_a.o_vga_addr), 32'd0);
    chk("A.midrst.active",  32'(if_a.o_active),   32'd0);
    chk("A.midrst.hsync",   32'(if_a.o_hsync),    32'd1);
    chk("A.midrst.blank_n", 32'(if_a.o_blank_n),  32'd0);
    rst_a = 1'b1;
    tick();
    chk("A.restart.addr",    32'(if_a.o_vga_addr),    32'd0);
    chk("A.restart.fs",      32'(if_a.o_frame_start), 32'd1);
    chk("A.restart.active",  32'(if_a.o_active),      32'd1);
    chk("A.restart.hsync",   32'(if_a.o_hsync),       32'd1);
    chk("A.restart.blank_n", 32'(if_a.o_blank_n),     32'd0);
    tick();
    chk("A.refill1.blank_n", 32'(if_a.o_blank_n),     32'd0);
    chk("A.refill1.fs",      32'(if_a.o_frame_start), 32'd0);
    tick();
    chk("A.refill2.blank_n", 32'(if_a.o_blank_n),     32'd1);
    chk("A.refill2.addr",    32'(if_a.o_vga_addr),    32'd2);

    // Random enable with rare resets on A.
    for (int i = 0; i < 3000; i++) begin
      en_a  = ($urandom_range(0, 3) != 0);
      rst_a = ($urandom_range(0, 999) != 0);
      tick();
    end
    rst_a = 1'b1; en_a = 1'b1;

    // DUT B: active-high sync with zero lag over one line, then a frame wrap.
    rst_b = 1'b1; en_b = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk($sformatf("B.line.hsync%0d", k), 32'(if_b.o_hsync),
          ((k >= 10 && k <= 12) ? 32'd1 : 32'd0));
      if (k == 0) chk("B.first.fs", 32'(if_b.o_frame_start), 32'd1);
    end
    for (int k = 15; k <= 120; k++) begin
      tick();
      if (k == 119) chk("B.lastcyc.addr", 32'(if_b.o_vga_addr), 32'd32);
    end
    chk("B.wrap.fs",   32'(if_b.o_frame_start), 32'd1);
    chk("B.wrap.addr", 32'(if_b.o_vga_addr),    32'd0);

    // Random enable with rare resets on B (many small frames).
    for (int i = 0; i < 1500; i++) begin
      en_b  = ($urandom_range(0, 3) != 0);
      rst_b = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
